// File: rtl/trojan_pattern_pkg.sv
// trojan_pattern_pkg: shared FSM state type, default LFSR constants and the Galois step function
package trojan_pattern_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam int MAX_W = 32;
    localparam logic [MAX_W-1:0] DEF_SEED = 32'h1;

    // Maximal-length right-shift Galois masks; widths outside 4..16 must pass POLY explicitly
    function automatic logic [MAX_W-1:0] default_poly(input int w);
        case (w)
            4:       return 32'h000C;
            5:       return 32'h0014;
            6:       return 32'h0030;
            7:       return 32'h0060;
            8:       return 32'h00B8;
            9:       return 32'h0110;
            10:      return 32'h0240;
            11:      return 32'h0500;
            12:      return 32'h0E08;
            13:      return 32'h1C80;
            14:      return 32'h3802;
            15:      return 32'h6000;
            16:      return 32'hD008;
            default: return '0;
        endcase
    endfunction

    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] poly);
        return x[0] ? ((x >> 1) ^ poly) : (x >> 1);
    endfunction

endpackage

// File: rtl/tpg_lfsr.sv
// tpg_lfsr: Galois LFSR register with load, step enable and all-zero seed substitution
module tpg_lfsr
    import trojan_pattern_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_d
);

    logic [WIDTH-1:0] r_lfsr;

    // o_d is the register's next value, letting the owner mirror it into an output register
    always_comb o_d = i_load ? ((i_seed == '0) ? SEED : i_seed)
                    : i_step ? WIDTH'(lfsr_next(MAX_W'(r_lfsr), MAX_W'(POLY)))
                    : r_lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_lfsr <= SEED;
        else       r_lfsr <= o_d;
    end

endmodule

// File: rtl/trojan_pattern_tx.sv
// trojan_pattern_tx: burst transmitter of LFSR test vectors over a valid/ready stream
module trojan_pattern_tx
    import trojan_pattern_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic [WIDTH-1:0] cfg_seed_i,
    input  logic [CNT_W-1:0] cfg_count_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] vec_o,
    output logic             vec_valid_o,
    input  logic             vec_ready_i,
    output logic             vec_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sent_o
);

    state_t           r_state, w_next;
    logic             w_load, w_step;
    logic [WIDTH-1:0] w_lfsr_d, r_vec;
    logic [CNT_W-1:0] r_remaining, r_sent;
    logic             r_valid, r_busy, r_done;

    tpg_lfsr #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_lfsr (
        .i_clk  (I1470_clk),
        .i_rst  (I1477_rst),
        .i_load (w_load),
        .i_seed (cfg_seed_i),
        .i_step (w_step),
        .o_d    (w_lfsr_d)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = start_i & (cfg_count_i != '0);
                if (start_i) w_next = w_load ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                w_step = vec_ready_i;
                if (abort_i | (w_step & (r_remaining == CNT_W'(1)))) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so every output but last is a flop
    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            r_state     <= ST_IDLE;
            r_vec       <= '0;
            r_remaining <= '0;
            r_sent      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == ST_RUN);
            r_busy  <= (w_next == ST_RUN);
            r_done  <= (w_next == ST_DONE);
            if (w_load | w_step) r_vec <= w_lfsr_d;
            if (r_state == ST_IDLE && start_i) begin
                r_remaining <= cfg_count_i;
                r_sent      <= '0;
            end else if (w_step) begin
                r_remaining <= r_remaining - CNT_W'(1);
                r_sent      <= (&r_sent) ? r_sent : r_sent + CNT_W'(1);
            end
        end
    end

    assign vec_o       = r_vec;
    assign vec_valid_o = r_valid;
    assign vec_last_o  = r_valid & (r_remaining == CNT_W'(1));
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign sent_o      = r_sent;

endmodule

// File: tb/tb_trojan_pattern_tx.sv
// tb_trojan_pattern_tx: directed self-checking bench for trojan_pattern_tx at WIDTH=8
module tb_trojan_pattern_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_seed = '0;
    logic [15:0] cfg_count = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  vec;
    logic        valid, last, busy, done;
    logic [15:0] sent;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    trojan_pattern_tx dut (
        .I1470_clk   (clk),
        .I1477_rst   (rst),
        .cfg_seed_i  (cfg_seed),
        .cfg_count_i (cfg_count),
        .start_i     (start),
        .abort_i     (abort),
        .vec_o       (vec),
        .vec_valid_o (valid),
        .vec_ready_i (ready),
        .vec_last_o  (last),
        .busy_o      (busy),
        .done_o      (done),
        .sent_o      (sent)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [7:0] v, input logic l, input logic [15:0] s);
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".vec"}, 32'(vec), 32'(v));
        chk({tag, ".last"}, 32'(last), 32'(l));
        chk({tag, ".sent"}, 32'(sent), 32'(s));
    endtask

    task automatic chk_done(input string tag, input logic [15:0] s);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".valid"}, 32'(valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".last"}, 32'(last), 32'd0);
        chk({tag, ".sent"}, 32'(s), 32'(sent));
    endtask

    task automatic go(input logic [7:0] seed, input logic [15:0] count);
        cfg_seed  = seed;
        cfg_count = count;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst.vec", 32'(vec), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.last", 32'(last), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.sent", 32'(sent), 32'd0);
        rst = 1'b0;
        tick();

        // basic burst, ready held high
        ready = 1'b1;
        go(8'h01, 16'd4);
        chk_vec("b1", 8'h01, 1'b0, 16'd0);
        tick();
        chk_vec("b2", 8'hB8, 1'b0, 16'd1);
        tick();
        chk_vec("b3", 8'h5C, 1'b0, 16'd2);
        tick();
        chk_vec("b4", 8'h2E, 1'b1, 16'd3);
        tick();
        chk_done("b.end", 16'd4);
        tick();
        chk("b.idle.done", 32'(done), 32'd0);
        chk("b.idle.sent", 32'(sent), 32'd4);

        // backpressure: three stalled cycles hold the first vector
        ready = 1'b0;
        go(8'h01, 16'd4);
        for (int i = 0; i < 3; i++) begin
            chk_vec("stall", 8'h01, 1'b0, 16'd0);
            tick();
        end
        chk_vec("s1", 8'h01, 1'b0, 16'd0);
        ready = 1'b1;
        tick();
        chk_vec("s2", 8'hB8, 1'b0, 16'd1);
        tick();
        chk_vec("s3", 8'h5C, 1'b0, 16'd2);
        tick();
        chk_vec("s4", 8'h2E, 1'b1, 16'd3);
        tick();
        chk_done("s.end", 16'd4);
        tick();

        // zero seed falls back to SEED
        go(8'h00, 16'd2);
        chk_vec("z1", 8'h01, 1'b0, 16'd0);
        tick();
        chk_vec("z2", 8'hB8, 1'b1, 16'd1);
        tick();
        chk_done("z.end", 16'd2);
        tick();

        // zero count goes straight to done
        go(8'h33, 16'd0);
        chk_done("c0", 16'd0);
        tick();
        chk("c0.idle.done", 32'(done), 32'd0);
        chk("c0.idle.valid", 32'(valid), 32'd0);

        // abort with the second transfer; start during RUN ignored
        go(8'h01, 16'd8);
        chk_vec("a1", 8'h01, 1'b0, 16'd0);
        cfg_seed  = 8'h55;
        cfg_count = 16'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk_vec("a2", 8'hB8, 1'b0, 16'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_done("a.end", 16'd2);
        tick();
        chk("a.idle.done", 32'(done), 32'd0);
        chk("a.idle.sent", 32'(sent), 32'd2);

        // abort in IDLE ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ai.done", 32'(done), 32'd0);
        chk("ai.sent", 32'(sent), 32'd2);

        // reset mid-burst after three transfers
        go(8'h01, 16'd8);
        tick();
        tick();
        tick();
        chk_vec("r4", 8'h2E, 1'b0, 16'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr.vec", 32'(vec), 32'd0);
        chk("mr.valid", 32'(valid), 32'd0);
        chk("mr.busy", 32'(busy), 32'd0);
        chk("mr.done", 32'(done), 32'd0);
        chk("mr.last", 32'(last), 32'd0);
        chk("mr.sent", 32'(sent), 32'd0);
        tick();
        chk("mr.nodone", 32'(done), 32'd0);
        go(8'h01, 16'd1);
        chk_vec("f1", 8'h01, 1'b1, 16'd0);
        tick();
        chk_done("f.end", 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trojan_pattern_tx.md
# trojan_pattern_tx

Stimulus transmitter for the trojan-detection netlist subcircuits. It generates a programmable-length stream of pseudo-random test vectors from a Galois LFSR and delivers them over a valid/ready interface. The consumer is the harness that applies each vector to a subcircuit's primary inputs, so this block is the driving end of that interface. It runs one pattern burst per start request, reports completion, and counts delivered vectors.

## Interface
Parameters:
- WIDTH, 8, vector width in bits (≥3)
- CNT_W, 16, width of the pattern count and sent counter
- POLY, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1), WIDTH bits
- SEED, 8'h01, fallback nonzero seed, WIDTH bits

Ports:
- I1470_clk  in  1  sole clock, all state on rising edge
- I1477_rst  in  1  synchronous, active-high reset
- cfg_seed_i  in  WIDTH  start seed, sampled on accepted start
- cfg_count_i  in  CNT_W  number of vectors to send, sampled on accepted start
- start_i  in  1  begin burst; accepted only in IDLE
- abort_i  in  1  terminate burst early; honored only in RUN
- vec_o  out  WIDTH  current vector
- vec_valid_o  out  1  vec_o valid
- vec_ready_i  in  1  consumer accepts vec_o
- vec_last_o  out  1  current vector is the final one of the burst
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle completion pulse
- sent_o  out  CNT_W  vectors transferred in the current or most recent burst

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start_i, count≠0: load lfsr with cfg_seed_i, or with SEED if cfg_seed_i==0 (all-zero lockup guard). Set remaining=count and sent=0. Go to RUN.
- IDLE + start_i, count==0: set sent=0 and go to DONE. No vector is emitted.
- RUN:
  - vec_valid_o=1 and vec_o=lfsr.
  - vec_last_o=(remaining==1).
  - Transfer = valid&ready. On a transfer: lfsr←next(lfsr), remaining−1, sent+1. If remaining was 1, go to DONE.
- next(x) = x[0] ? (x>>1)^POLY : x>>1.
- Backpressure: while valid&!ready, vec_o, vec_last_o and the counters hold.
- abort_i in RUN: go to DONE. If a transfer occurs in the same cycle, it is counted first.
- start_i outside IDLE is ignored. abort_i outside RUN is ignored.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. sent_o holds until the next accepted start.
- vec_valid_o, vec_last_o and busy_o are 0 in IDLE and DONE.

## Timing
- Reset values: state=IDLE, lfsr=SEED, remaining=0, sent_o=0, vec_o=0, vec_valid_o=0, vec_last_o=0, busy_o=0, done_o=0.
- Reset asserted mid-burst returns to the reset values on the next edge. No done_o pulse is generated.
- Start at edge t: vec_valid_o high from cycle t+1 with vec_o=seed.
- Throughput is 1 vector/cycle with ready held high.
- Last transfer at edge k: done_o high and busy_o low in cycle k+1. A new start is accepted at edge k+2.
- count==0 start at t: done_o high in cycle t+1.
- vec_o is registered and glitch-free. All outputs are registered except vec_last_o, which is decoded from registered state.
- Sequence period is 2^WIDTH−1 for a maximal POLY. Counts beyond the period wrap the sequence without error.
- sent_o saturates at 2^CNT_W−1.

## Structure
- Package trojan_pattern_pkg holds:
  - the state enum
  - default POLY/SEED constants for WIDTH 4..16
  - function lfsr_next(x, poly)
- Sub-module tpg_lfsr owns the LFSR register: load, enable step, and zero-seed substitution. The top level holds the FSM, counters and handshake.

## Test plan
- WIDTH=8, seed 0x01, count 4, ready=1: vectors 01, B8, 5C, 2E on consecutive cycles. vec_last_o high only with 2E. done_o one cycle later, sent_o=4.
- Same burst with ready low 3 cycles after first valid: vec_o holds 01, no advance, sent_o=0 during the stall. Stream resumes 01, B8, … with no skipped value.
- seed 0x00, count 2: vectors 01, B8, because the SEED fallback is applied.
- count 0: done_o pulses at t+1, vec_valid_o never asserts, sent_o=0.
- abort_i asserted together with the 2nd transfer: valid drops the next cycle, done_o pulses, sent_o=2. A start_i during RUN is ignored.
- Reset mid-burst after 3 transfers: all outputs 0 on the next cycle, no done_o. A fresh start then emits the seed first.
